// File: rtl/div.sv
// Sequential 16/8 unsigned restoring divider: one quotient bit per clock, 16 WORK cycles per result.
// Optional macro DIV_ZERO_CHECK_EN: a zero divisor completes at the start edge with err_o=1.
`timescale 1ns/1ps
module div (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] a_bi,
    input  logic [7:0]  b_bi,
    input  logic        start_i,
    output logic        busy_o,
    output logic [15:0] q_bo,
    output logic [7:0]  r_bo,
    output logic        err_o
);

    typedef enum logic {IDLE, WORK} state_t;

    state_t      state, state_nxt;
    logic [3:0]  ctr;
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [7:0]  rem;
    logic [15:0] quo;
    logic [8:0]  rs;
    logic        ge;
    logic [7:0]  rem_nxt;
    logic        last;
    logic        zero_start;

`ifdef DIV_ZERO_CHECK_EN
    assign zero_start = (b_bi == 8'd0);
`else
    assign zero_start = 1'b0;
`endif

    // One restoring step; the difference always fits 8 bits because rs < 2*divisor.
    always_comb begin
        rs      = {rem, dvd[4'd15 - ctr]};
        ge      = (rs >= {1'b0, dvs});
        rem_nxt = ge ? (rs[7:0] - dvs) : rs[7:0];
        last    = (ctr == 4'd15);
    end

    // NOTE: sequential state uses non-blocking assignments with an asynchronous reset in the sensitivity list.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_i && !zero_start) state_nxt = WORK;
            WORK: if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o = start_i | (state == WORK);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ctr  <= 4'd0;
            dvd  <= 16'd0;
            dvs  <= 8'd0;
            rem  <= 8'd0;
            quo  <= 16'd0;
            q_bo <= 16'd0;
            r_bo <= 8'd0;
        end else if (state == IDLE) begin
            if (start_i && !zero_start) begin
                dvd <= a_bi;
                dvs <= b_bi;
                ctr <= 4'd0;
                rem <= 8'd0;
                quo <= 16'd0;
            end
`ifdef DIV_ZERO_CHECK_EN
            else if (start_i) begin
                q_bo <= 16'hFFFF;
                r_bo <= a_bi[7:0];
            end
`endif
        end else begin
            rem <= rem_nxt;
            quo <= {quo[14:0], ge};
            ctr <= ctr + 4'd1;
            if (last) begin
                q_bo <= {quo[14:0], ge};
                r_bo <= rem_nxt;
            end
        end
    end

`ifdef DIV_ZERO_CHECK_EN
    logic err_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_q <= 1'b0;
        end else if (state == IDLE && start_i && zero_start) begin
            err_q <= 1'b1;
        end else if (state == WORK && last) begin
            err_q <= 1'b0;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: stimulus pushes expected results tagged with their due cycle,
// a negedge monitor pops and compares them when that cycle arrives.
`timescale 1ns/1ps
module tb_div;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        err;
        int          due;
    } exp_t;

`ifdef DIV_ZERO_CHECK_EN
    localparam int ZLAT = 0;
    localparam logic ZERR = 1'b1;
`else
    localparam int ZLAT = 16;
    localparam logic ZERR = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] a_bi;
    logic [7:0]  b_bi;
    logic        start_i;
    logic        busy_o;
    logic [15:0] q_bo;
    logic [7:0]  r_bo;
    logic        err_o;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    div dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .a_bi    (a_bi),
        .b_bi    (b_bi),
        .start_i (start_i),
        .busy_o  (busy_o),
        .q_bo    (q_bo),
        .r_bo    (r_bo),
        .err_o   (err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec = n_vec + 1;
        if (act !== req) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    task automatic push(input logic [15:0] q, input logic [7:0] r, input logic err, input int due);
        exp_t e;
        e.q = q; e.r = r; e.err = err; e.due = due;
        sb.push_back(e);
    endtask

    // Drive a one-cycle start pulse; returns the cycle number of the sampling edge.
    task automatic issue(input logic [15:0] a, input logic [7:0] b, input logic [15:0] q,
                         input logic [7:0] r, input logic err, input int lat, output int s);
        @(negedge clk_i);
        a_bi = a; b_bi = b; start_i = 1'b1;
        s = cyc + 1;
        push(q, r, err, s + lat);
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_i);
    endtask

    task automatic run(input logic [15:0] a, input logic [7:0] b, input logic [15:0] q,
                       input logic [7:0] r);
        int s;
        issue(a, b, q, r, 1'b0, 16, s);
        wait_neg(17);
    endtask

    // Monitor: compare every result whose due cycle has arrived.
    always @(negedge clk_i) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.due < cyc) begin
                n_vec = n_vec + 1;
                n_err = n_err + 1;
                $display("FAIL overdue: result due at cycle %0d not checked by cycle %0d", e.due, cyc);
            end else begin
                check("q_bo", {16'd0, q_bo}, {16'd0, e.q});
                check("r_bo", {24'd0, r_bo}, {24'd0, e.r});
                check("err_o", {31'd0, err_o}, {31'd0, e.err});
            end
        end
    end

    initial begin
        int s;
        int cnt;
        rst_i = 1'b0; a_bi = 16'd0; b_bi = 8'd0; start_i = 1'b0;
        wait_neg(3);
        check("rst busy_o", {31'd0, busy_o}, 32'd0);
        check("rst q_bo", {16'd0, q_bo}, 32'd0);
        check("rst r_bo", {24'd0, r_bo}, 32'd0);
        check("rst err_o", {31'd0, err_o}, 32'd0);
        rst_i = 1'b1;
        wait_neg(2);

        // 1000/7 with busy-length measurement: start cycle plus 16 WORK cycles.
        @(negedge clk_i);
        a_bi = 16'd1000; b_bi = 8'd7; start_i = 1'b1;
        s = cyc + 1;
        push(16'd142, 8'd6, 1'b0, s + 16);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!busy_o) break;
            cnt = cnt + 1;
            @(negedge clk_i);
            start_i = 1'b0;
        end
        check("busy length", cnt, 32'd17);
        wait_neg(2);

        run(16'd65535, 8'd255, 16'd257, 8'd0);
        issue(16'd5, 8'd10, 16'd0, 8'd5, 1'b0, 16, s);
        wait_neg(6);
        check("hold q_bo", {16'd0, q_bo}, 32'd257);
        check("hold r_bo", {24'd0, r_bo}, 32'd0);
        check("busy mid-op", {31'd0, busy_o}, 32'd1);
        wait_neg(11);

        run(16'd12345, 8'd100, 16'd123, 8'd45);
        run(16'd255, 8'd16, 16'd15, 8'd15);
        run(16'd65535, 8'd1, 16'd65535, 8'd0);
        run(16'd0, 8'd1, 16'd0, 8'd0);

        // Back-to-back with start held high; a_bi changes mid-operation.
        @(negedge clk_i);
        a_bi = 16'd100; b_bi = 8'd3; start_i = 1'b1;
        s = cyc + 1;
        push(16'd33, 8'd1, 1'b0, s + 16);
        push(16'd66, 8'd2, 1'b0, s + 33);
        wait_neg(5);
        a_bi = 16'd200;
        for (int i = 0; i < 40 && cyc < s + 17; i++) @(negedge clk_i);
        check("b2b busy", {31'd0, busy_o}, 32'd1);
        start_i = 1'b0;
        wait_neg(18);

        // Divide by zero: 1234 = 0x4D2.
        issue(16'd1234, 8'd0, 16'hFFFF, 8'hD2, ZERR, ZLAT, s);
        #1;
        check("zero busy", {31'd0, busy_o}, (ZLAT == 0) ? 32'd0 : 32'd1);
        wait_neg(ZLAT + 1);

        // Asynchronous reset at WORK step 8 aborts the operation.
        issue(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 16, s);
        wait_neg(7);
        #2;
        rst_i = 1'b0;
        sb.delete();
        #1;
        check("abort busy", {31'd0, busy_o}, 32'd0);
        check("abort q_bo", {16'd0, q_bo}, 32'd0);
        check("abort r_bo", {24'd0, r_bo}, 32'd0);
        check("abort err_o", {31'd0, err_o}, 32'd0);
        wait_neg(2);
        rst_i = 1'b1;
        wait_neg(1);
        run(16'd50, 8'd7, 16'd7, 8'd1);

        wait_neg(3);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_vec = n_vec + 1;
            n_err = n_err + 1;
            $display("FAIL pending: result due at cycle %0d never checked", e.due);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
